motor_speed_sched: RTL and testbench
====================================

Name: motor_speed_sched

Overview:
Sequencer between the 4-bit ADC code inputs, the PWM motor stage and the LCD writer. It debounces the ADC code into a speed target and ramps the PWM duty level toward it one step per ramp tick. After each settled change it notifies the LCD through a four-phase req/ack handshake. It replaces the direct wiring of the raw ADC code into the motor and LCD blocks.

Parameters:
TICK_DIV, 1_000_000, clock cycles per ramp step (10 ms at 100 MHz); minimum 2.
STABLE_SAMPLES, 3, number of consecutive equal strobed ADC samples required to accept a new target; minimum 1.
LCD_TIMEOUT, 2_000_000, cycles to wait for lcd_ack (assert or release) before declaring a fault.

Ports:
clock_100Mhz  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
adc_code  in  4  ADC code, bit 3 = bit_A ... bit 0 = bit_D; sampled only on sample_strobe.
sample_strobe  in  1  single-cycle sample pulse from the pulse generator.
activate  in  1  motor enable request; asynchronous, synchronised internally with 2 flops.
duty_level  out  4  duty step to the PWM stage; 0 = off, 15 = max.
motor_en  out  1  high whenever the FSM is not in OFF.
lcd_req  out  1  LCD update request.
lcd_code  out  4  value to display; stable while lcd_req is high.
lcd_ack  in  1  LCD acknowledge, four-phase.
lcd_fault  out  1  sticky flag, set on handshake timeout.
busy  out  1  high in RAMP, NOTIFY and RELEASE.

Behaviour:
- Reset (reset=0, takes effect immediately): all outputs 0. FSM=OFF. target=0, candidate=0, sample count=0, tick counter=0, timeout counter=0, sync flops=0.
- Filter, on sample_strobe only:
  - adc_code==candidate: count increments, saturating at STABLE_SAMPLES.
  - Otherwise: candidate<=adc_code, count<=1.
  - On the cycle count reaches STABLE_SAMPLES: target<=candidate, visible the next cycle. While saturated, target follows candidate.
- eff_target = activate_s ? target : 0.
- Tick counter:
  - Free-runs 0..TICK_DIV-1 and wraps.
  - tick=1 for one cycle at TICK_DIV-1.
  - Counts in every state.
- FSM states: OFF, RAMP, NOTIFY, RELEASE, RUN.
  - OFF: duty_level=0, motor_en=0. activate_s=1 goes to RAMP.
  - RAMP:
    - On tick, duty moves one step toward eff_target: +1 if below, -1 if above. No wrap; duty stays within 0..15.
    - When duty==eff_target, checked after the step or on entry, go to NOTIFY and latch lcd_code<=duty.
  - NOTIFY:
    - lcd_req=1 and the timeout counter runs.
    - lcd_ack=1 goes to RELEASE; lcd_req drops in the next cycle.
    - Timeout: set lcd_fault, drop lcd_req, go to RELEASE.
  - RELEASE:
    - lcd_req=0. Wait for lcd_ack=0, or for timeout, which also sets lcd_fault.
    - Then go to OFF if activate_s=0 and duty=0, else to RUN.
  - RUN: eff_target!=duty goes to RAMP. Entry into RAMP does not wait for a tick; the first step happens on the next tick.
- Simultaneous events:
  - Strobe and tick in the same cycle: the ramp uses the old target.
  - Target changes during NOTIFY or RELEASE are held, then picked up in RUN.
  - Deasserting activate mid-ramp reverses direction at the next tick.
- lcd_fault clears only on reset.
- Worst-case latency from target change to first duty step is TICK_DIV cycles.

Decomposition:
- Shared package: FSM state encoding (3-bit localparams OFF=0, RAMP=1, NOTIFY=2, RELEASE=3, RUN=4), duty width constant 4, DUTY_MAX=15.
- One natural sub-module: adc_stable_filter, containing the candidate/count/target logic with parameter STABLE_SAMPLES.
- The tick counter, FSM and handshake stay in the top of the block.

Test Plan (TICK_DIV=4, STABLE_SAMPLES=3, LCD_TIMEOUT=16):
1. Hold reset=0 with adc_code=9 and strobes running -> duty_level=0, motor_en=0, lcd_req=0, lcd_fault=0, busy=0.
2. activate=1, three strobes of adc_code=9, ack returned 2 cycles after req -> duty steps 1..9 one per 4 cycles; lcd_req with lcd_code=9; after ack falls, FSM=RUN and busy=0.
3. In RUN at 9, strobes with codes 5,5,9,5,5,5 -> target stays 9 until the third consecutive 5, then ramps down 8,7,6,5 and notifies with lcd_code=5.
4. In RUN at 5, drop activate -> ramps down to 0, notifies with lcd_code=0, then OFF with motor_en=0.
5. lcd_ack tied low during a notify -> lcd_req drops after 16 cycles, lcd_fault=1 and stays set, FSM reaches RUN.
6. Assert reset=0 asynchronously mid-ramp at duty 4 with lcd_req idle -> duty_level=0 before the next clock edge; after release, FSM=OFF.

Source files
------------

// File: rtl/motor_speed_sched_pkg.sv
// Shared encodings and helpers for the motor speed sequencer.
// Holds the FSM state codes, the duty width and the duty step rule.
package motor_speed_sched_pkg;

    localparam int DUTY_W = 4;
    localparam logic [DUTY_W-1:0] DUTY_MAX = 4'd15;
    localparam logic [DUTY_W-1:0] DUTY_MIN = 4'd0;

    typedef logic [2:0] state_t;

    localparam state_t ST_OFF     = 3'd0;
    localparam state_t ST_RAMP    = 3'd1;
    localparam state_t ST_NOTIFY  = 3'd2;
    localparam state_t ST_RELEASE = 3'd3;
    localparam state_t ST_RUN     = 3'd4;

    // One duty step toward the target, clamped to the 0..DUTY_MAX range.
    function automatic logic [DUTY_W-1:0] step_toward(input logic [DUTY_W-1:0] cur,
                                                      input logic [DUTY_W-1:0] tgt);
        logic [DUTY_W-1:0] res;
        if ((cur < tgt) && (cur != DUTY_MAX)) begin
            res = cur + 4'd1;
        end else if ((cur > tgt) && (cur != DUTY_MIN)) begin
            res = cur - 4'd1;
        end else begin
            res = cur;
        end
        return res;
    endfunction

endpackage

// File: rtl/motor_speed_sched_adc_stable_filter.sv
// Debounces strobed ADC codes: a code becomes the target only after
// STABLE_SAMPLES consecutive equal strobed samples.
module adc_stable_filter
    import motor_speed_sched_pkg::*;
#(
    parameter int STABLE_SAMPLES = 3
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              strobe_i,
    input  logic [DUTY_W-1:0] code_i,
    output logic [DUTY_W-1:0] target_o
);

    localparam int CNT_W = $clog2(STABLE_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(STABLE_SAMPLES);

    logic [DUTY_W-1:0] cand_q, cand_d;
    logic [DUTY_W-1:0] target_q, target_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    // Candidate/count update on strobes; target copies candidate once saturated.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        target_d = target_q;
        if (strobe_i) begin
            if (code_i == cand_q) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else begin
                    cnt_d = cnt_q;
                end
            end else begin
                cand_d = code_i;
                cnt_d  = CNT_W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
        if (cnt_q == CNT_SAT) begin
            target_d = cand_q;
        end else begin
            target_d = target_q;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cand_q   <= 4'd0;
            cnt_q    <= {CNT_W{1'b0}};
            target_q <= 4'd0;
        end else begin
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            target_q <= target_d;
        end
    end

    assign target_o = target_q;

endmodule

// File: rtl/motor_speed_sched.sv
// Motor speed sequencer: debounced ADC target, tick-paced duty ramp and
// a four-phase req/ack notification to the LCD writer after each settle.
module motor_speed_sched
    import motor_speed_sched_pkg::*;
#(
    parameter int TICK_DIV       = 1_000_000,
    parameter int STABLE_SAMPLES = 3,
    parameter int LCD_TIMEOUT    = 2_000_000
) (
    input  logic              clock_100Mhz,
    input  logic              reset,
    input  logic [DUTY_W-1:0] adc_code,
    input  logic              sample_strobe,
    input  logic              activate,
    output logic [DUTY_W-1:0] duty_level,
    output logic              motor_en,
    output logic              lcd_req,
    output logic [DUTY_W-1:0] lcd_code,
    input  logic              lcd_ack,
    output logic              lcd_fault,
    output logic              busy
);

    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TO_W   = $clog2(LCD_TIMEOUT + 1);

    logic [1:0]        sync_q;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    state_t            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] code_q, code_d;
    logic              fault_q, fault_d;
    logic              en_q, en_d, req_q, req_d, busy_q, busy_d;
    logic              activate_s, tick_s, to_expired_s;
    logic [DUTY_W-1:0] target_s, eff_target_s, duty_step_s;

    adc_stable_filter #(
        .STABLE_SAMPLES(STABLE_SAMPLES)
    ) u_filter (
        .clk_i   (clock_100Mhz),
        .rst_n_i (reset),
        .strobe_i(sample_strobe),
        .code_i  (adc_code),
        .target_o(target_s)
    );

    assign activate_s   = sync_q[1];
    assign eff_target_s = activate_s ? target_s : 4'd0;
    assign tick_s       = (tick_cnt_q == TICK_W'(TICK_DIV - 1));
    assign to_expired_s = (to_cnt_q == TO_W'(LCD_TIMEOUT - 1));
    assign duty_step_s  = tick_s ? step_toward(duty_q, eff_target_s) : duty_q;

    // Free-running ramp tick divider and handshake timeout counter.
    always_comb begin
        tick_cnt_d = tick_s ? {TICK_W{1'b0}} : (tick_cnt_q + TICK_W'(1));
        if (state_d != state_q) begin
            to_cnt_d = {TO_W{1'b0}};
        end else if ((state_q == ST_NOTIFY) || (state_q == ST_RELEASE)) begin
            to_cnt_d = to_cnt_q + TO_W'(1);
        end else begin
            to_cnt_d = {TO_W{1'b0}};
        end
    end

    // Next-state logic, including duty stepping and fault capture.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        code_d  = code_q;
        fault_d = fault_q;
        case (state_q)
            ST_OFF: begin
                if (activate_s) state_d = ST_RAMP;
                else            state_d = ST_OFF;
            end
            ST_RAMP: begin
                duty_d = duty_step_s;
                if (duty_step_s == eff_target_s) begin
                    state_d = ST_NOTIFY;
                    code_d  = duty_step_s;
                end else begin
                    state_d = ST_RAMP;
                end
            end
            ST_NOTIFY: begin
                if (lcd_ack) begin
                    state_d = ST_RELEASE;
                end else if (to_expired_s) begin
                    state_d = ST_RELEASE;
                    fault_d = 1'b1;
                end else begin
                    state_d = ST_NOTIFY;
                end
            end
            ST_RELEASE: begin
                if (!lcd_ack || to_expired_s) begin
                    fault_d = fault_q | lcd_ack;
                    if (!activate_s && (duty_q == 4'd0)) state_d = ST_OFF;
                    else                                 state_d = ST_RUN;
                end else begin
                    state_d = ST_RELEASE;
                end
            end
            ST_RUN: begin
                if (eff_target_s != duty_q) state_d = ST_RAMP;
                else                        state_d = ST_RUN;
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    // Output decode from the next state so every output leaves a flop.
    always_comb begin
        en_d   = 1'b1;
        req_d  = 1'b0;
        busy_d = 1'b0;
        case (state_d)
            ST_OFF:     en_d = 1'b0;
            ST_RAMP:    busy_d = 1'b1;
            ST_NOTIFY:  begin req_d = 1'b1; busy_d = 1'b1; end
            ST_RELEASE: busy_d = 1'b1;
            ST_RUN:     busy_d = 1'b0;
            default:    en_d = 1'b0;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock_100Mhz or negedge reset) begin
        if (!reset) begin
            sync_q     <= 2'b00;
            tick_cnt_q <= {TICK_W{1'b0}};
            to_cnt_q   <= {TO_W{1'b0}};
            state_q    <= ST_OFF;
            duty_q     <= 4'd0;
            code_q     <= 4'd0;
            fault_q    <= 1'b0;
            en_q       <= 1'b0;
            req_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            sync_q     <= {sync_q[0], activate};
            tick_cnt_q <= tick_cnt_d;
            to_cnt_q   <= to_cnt_d;
            state_q    <= state_d;
            duty_q     <= duty_d;
            code_q     <= code_d;
            fault_q    <= fault_d;
            en_q       <= en_d;
            req_q      <= req_d;
            busy_q     <= busy_d;
        end
    end

    assign duty_level = duty_q;
    assign motor_en   = en_q;
    assign lcd_req    = req_q;
    assign lcd_code   = code_q;
    assign lcd_fault  = fault_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_motor_speed_sched.sv
// Self-checking bench for motor_speed_sched with a strobe-history target model.
module tb_motor_speed_sched;

    localparam int TICK_DIV       = 4;
    localparam int STABLE_SAMPLES = 3;
    localparam int LCD_TIMEOUT    = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] adc = 4'd0;
    logic       strobe = 1'b0;
    logic       act = 1'b0;
    logic       ack = 1'b0;
    logic [3:0] duty_level, lcd_code;
    logic       motor_en, lcd_req, lcd_fault, busy;

    int checks = 0;
    int failures = 0;
    int hist[$];
    bit exp_fault = 1'b0;

    motor_speed_sched #(
        .TICK_DIV(TICK_DIV), .STABLE_SAMPLES(STABLE_SAMPLES), .LCD_TIMEOUT(LCD_TIMEOUT)
    ) dut (
        .clock_100Mhz(clk), .reset(rst_n), .adc_code(adc), .sample_strobe(strobe),
        .activate(act), .duty_level(duty_level), .motor_en(motor_en), .lcd_req(lcd_req),
        .lcd_code(lcd_code), .lcd_ack(ack), .lcd_fault(lcd_fault), .busy(busy)
    );

    always #5 clk = ~clk;

    // Target = value of the most recent run of >= STABLE_SAMPLES equal strobed codes.
    function automatic int model_target();
        int tgt = 0;
        int run = 0;
        int last = -1;
        foreach (hist[i]) begin
            if (hist[i] == last) run++;
            else begin last = hist[i]; run = 1; end
            if (run >= STABLE_SAMPLES) tgt = last;
        end
        return tgt;
    endfunction

    function automatic int exp_eff();
        return act ? model_target() : 0;
    endfunction

    task automatic do_strobe(input logic [3:0] c);
        repeat ($urandom_range(0, 2)) @(negedge clk);
        adc = c;
        strobe = 1'b1;
        @(negedge clk);
        strobe = 1'b0;
        hist.push_back(int'(c));
    endtask

    task automatic wait_settle(input string nm, input int ack_dly, input bit ack_never);
        int exp_v;
        int prev;
        int since;
        int hi;
        bit got;
        exp_v = exp_eff();
        prev  = int'(duty_level);
        since = -1;
        got   = 1'b0;
        for (int cyc = 0; cyc < 40 * TICK_DIV; cyc++) begin
            @(negedge clk);
            if (int'(duty_level) != prev) begin
                checks++;
                if (!((exp_v > prev && int'(duty_level) == prev + 1) ||
                      (exp_v < prev && int'(duty_level) == prev - 1))) begin
                    failures++;
                    $display("FAIL %s step: duty=%0d prev=%0d target=%0d", nm, duty_level, prev, exp_v);
                end
                checks++;
                if (since >= 0 && cyc - since != TICK_DIV) begin
                    failures++;
                    $display("FAIL %s spacing: got %0d cycles want %0d", nm, cyc - since, TICK_DIV);
                end else if (since < 0 && cyc > TICK_DIV + 4) begin
                    failures++;
                    $display("FAIL %s first_step_latency: got %0d want <= %0d", nm, cyc, TICK_DIV + 4);
                end
                since = cyc;
                prev  = int'(duty_level);
            end
            if (lcd_req === 1'b1) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            failures++;
            $display("FAIL %s req_timeout: lcd_req=%b want 1", nm, lcd_req);
        end else begin
            checks++;
            if (int'(lcd_code) != exp_v) begin
                failures++;
                $display("FAIL %s lcd_code: got %0d want %0d", nm, lcd_code, exp_v);
            end
            checks++;
            if (int'(duty_level) != exp_v) begin
                failures++;
                $display("FAIL %s duty_at_notify: got %0d want %0d", nm, duty_level, exp_v);
            end
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL %s busy_notify: got %b want 1", nm, busy);
            end
            if (!ack_never) begin
                repeat (ack_dly) @(negedge clk);
                ack = 1'b1;
                @(negedge clk);
                checks++;
                if (lcd_req !== 1'b0) begin
                    failures++;
                    $display("FAIL %s req_drop: got %b want 0", nm, lcd_req);
                end
                repeat ($urandom_range(0, 3)) @(negedge clk);
                ack = 1'b0;
            end else begin
                hi = 1;
                while (hi < LCD_TIMEOUT + 8) begin
                    @(negedge clk);
                    if (lcd_req === 1'b1) hi++;
                    else break;
                end
                checks++;
                if (hi != LCD_TIMEOUT) begin
                    failures++;
                    $display("FAIL %s req_high_cycles: got %0d want %0d", nm, hi, LCD_TIMEOUT);
                end
                exp_fault = 1'b1;
            end
            repeat (2) @(negedge clk);
        end
        checks++;
        if (busy !== 1'b0 || int'(duty_level) != exp_v) begin
            failures++;
            $display("FAIL %s settled: busy=%b duty=%0d want busy=0 duty=%0d", nm, busy, duty_level, exp_v);
        end
        checks++;
        if (motor_en !== (act || exp_v != 0)) begin
            failures++;
            $display("FAIL %s motor_en: got %b want %b", nm, motor_en, (act || exp_v != 0));
        end
        checks++;
        if (lcd_fault !== exp_fault) begin
            failures++;
            $display("FAIL %s lcd_fault: got %b want %b", nm, lcd_fault, exp_fault);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        act = 1'b0;
        for (int i = 0; i < 4; i++) begin
            adc = 4'd9; strobe = 1'b1; @(negedge clk);
            strobe = 1'b0; @(negedge clk);
        end
        checks++;
        if (duty_level !== 4'd0 || motor_en !== 1'b0 || lcd_req !== 1'b0 ||
            lcd_fault !== 1'b0 || busy !== 1'b0 || lcd_code !== 4'd0) begin
            failures++;
            $display("FAIL reset_outputs: duty=%0d en=%b req=%b fault=%b busy=%b code=%0d want all 0",
                     duty_level, motor_en, lcd_req, lcd_fault, busy, lcd_code);
        end
        rst_n = 1'b1;
        hist.delete();
        repeat (3) @(negedge clk);
        checks++;
        if (motor_en !== 1'b0 || duty_level !== 4'd0) begin
            failures++;
            $display("FAIL reset_idle: en=%b duty=%0d want 0 0", motor_en, duty_level);
        end
    endtask

    task automatic test_rampup();
        repeat (3) do_strobe(4'd9);
        act = 1'b1;
        wait_settle("rampup", 2, 1'b0);
    endtask

    task automatic test_filter();
        do_strobe(4'd5); do_strobe(4'd5); do_strobe(4'd9);
        do_strobe(4'd5); do_strobe(4'd5);
        repeat (3 * TICK_DIV) @(negedge clk);
        checks++;
        if (duty_level !== 4'd9 || busy !== 1'b0) begin
            failures++;
            $display("FAIL filter_hold: duty=%0d busy=%b want 9 0", duty_level, busy);
        end
        do_strobe(4'd5);
        wait_settle("filter", int'($urandom_range(0, 5)), 1'b0);
    endtask

    task automatic test_deactivate();
        act = 1'b0;
        wait_settle("deactivate", int'($urandom_range(0, 5)), 1'b0);
    endtask

    task automatic test_random();
        logic [3:0] c, n0, n1;
        for (int it = 0; it < 6; it++) begin
            do c = 4'($urandom_range(0, 15)); while (int'(c) == exp_eff());
            do n0 = 4'($urandom_range(0, 15)); while (n0 == c);
            do n1 = 4'($urandom_range(0, 15)); while (n1 == c);
            do_strobe(n0); do_strobe(n1);
            repeat (3) do_strobe(c);
            act = 1'b1;
            wait_settle("random", int'($urandom_range(0, 5)), 1'b0);
        end
    endtask

    task automatic test_timeout();
        logic [3:0] c;
        c = (model_target() == 12) ? 4'd13 : 4'd12;
        repeat (3) do_strobe(c);
        wait_settle("timeout", 0, 1'b1);
    endtask

    task automatic test_reset_midramp();
        bit hit;
        hit = 1'b0;
        repeat (3) do_strobe(4'd0);
        for (int i = 0; i < 40 * TICK_DIV; i++) begin
            @(negedge clk);
            if (duty_level === 4'd4) begin hit = 1'b1; break; end
        end
        checks++;
        if (!hit || lcd_req !== 1'b0 || busy !== 1'b1 || lcd_fault !== 1'b1) begin
            failures++;
            $display("FAIL midramp_reach: hit=%b req=%b busy=%b fault=%b want 1 0 1 1",
                     hit, lcd_req, busy, lcd_fault);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (duty_level !== 4'd0 || motor_en !== 1'b0 || busy !== 1'b0 || lcd_fault !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: duty=%0d en=%b busy=%b fault=%b want all 0",
                     duty_level, motor_en, busy, lcd_fault);
        end
        act = 1'b0;
        hist.delete();
        exp_fault = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        checks++;
        if (motor_en !== 1'b0 || busy !== 1'b0 || duty_level !== 4'd0) begin
            failures++;
            $display("FAIL after_reset_off: en=%b busy=%b duty=%0d want 0 0 0", motor_en, busy, duty_level);
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_rampup();
        test_filter();
        test_deactivate();
        test_random();
        test_timeout();
        test_reset_midramp();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
